// File: rtl/pixel_array_readout.sv
// Frame sequencer and readout controller for a 2x2 pixel array on a shared DATA bus.
// Optional FRAME_CNT_EN adds a frame counter and an overrun pulse for starts seen while busy.
module pixel_array_readout #(
   parameter int DATA_W     = 8,
   parameter int ERASE_CYC  = 5,
   parameter int EXPOSE_CYC = 255,
   parameter int READ_CYC   = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              ERASE,
   output logic              EXPOSE,
   output logic              CONVERT,
   output logic              READ1,
   output logic              READ2,
   output logic              READ3,
   output logic              READ4,
   output logic [DATA_W-1:0] DATA_OUT,
   output logic              DATA_OE,
   input  logic [DATA_W-1:0] DATA_IN,
   output logic [DATA_W-1:0] pix_data,
   output logic [1:0]        pix_idx,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              busy,
   output logic              frame_done
`ifdef FRAME_CNT_EN
   ,
   output logic [15:0]       frame_cnt,
   output logic              overrun
`endif
);

   localparam int CONV_CYC = 1 << DATA_W;
   localparam int MAX_A    = (ERASE_CYC > EXPOSE_CYC) ? ERASE_CYC : EXPOSE_CYC;
   localparam int MAX_B    = (CONV_CYC > READ_CYC) ? CONV_CYC : READ_CYC;
   localparam int MAX_LEN  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W    = ($clog2(MAX_LEN) < 1) ? 1 : $clog2(MAX_LEN);

   localparam logic [CNT_W-1:0] ERASE_LAST  = CNT_W'(ERASE_CYC - 1);
   localparam logic [CNT_W-1:0] EXPOSE_LAST = CNT_W'(EXPOSE_CYC - 1);
   localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYC - 1);
   localparam logic [CNT_W-1:0] READ_LAST   = CNT_W'(READ_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_TURN, S_READ, S_HOLD, S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic              erase_q, erase_d;
   logic              expose_q, expose_d;
   logic              convert_q, convert_d;
   logic [3:0]        read_q, read_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              data_oe_q, data_oe_d;
   logic [DATA_W-1:0] pix_data_q, pix_data_d;
   logic [1:0]        pix_idx_q, pix_idx_d;
   logic              pix_valid_q, pix_valid_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
`ifdef FRAME_CNT_EN
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic              overrun_q, overrun_d;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      pix_data_d   = pix_data_q;
      pix_idx_d    = pix_idx_q;
      pix_valid_d  = pix_valid_q;
      frame_done_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_ERASE;
         end
         S_ERASE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ERASE_LAST) state_d = S_EXPOSE;
         end
         S_EXPOSE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == EXPOSE_LAST) state_d = S_CONVERT;
         end
         S_CONVERT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CONV_LAST) state_d = S_TURN;
         end
         S_TURN: begin
            state_d = S_READ;
            idx_d   = 2'd0;
         end
         S_READ: begin
            cnt_d = cnt_q + 1'b1;
            // Capture on the last READ cycle while the pixel still drives the bus.
            if (cnt_q == READ_LAST) begin
               state_d     = S_HOLD;
               pix_data_d  = DATA_IN;
               pix_idx_d   = idx_q;
               pix_valid_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (pix_ready) begin
               pix_valid_d = 1'b0;
               if (idx_q == 2'd3) begin
                  state_d      = S_IDLE;
                  frame_done_d = 1'b1;
               end else begin
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            state_d = S_READ;
            idx_d   = idx_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) cnt_d = '0;

      // Outputs are decoded from the next state so they are registered, glitch-free.
      erase_d    = (state_d == S_ERASE);
      expose_d   = (state_d == S_EXPOSE);
      convert_d  = (state_d == S_CONVERT);
      data_oe_d  = (state_d == S_CONVERT);
      data_out_d = (state_d == S_CONVERT) ? DATA_W'(cnt_d) : '0;
      read_d     = (state_d == S_READ) ? (4'b0001 << idx_d) : 4'b0000;
      busy_d     = (state_d != S_IDLE);
`ifdef FRAME_CNT_EN
      overrun_d   = start && (state_q != S_IDLE);
      frame_cnt_d = frame_done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         erase_q      <= 1'b0;
         expose_q     <= 1'b0;
         convert_q    <= 1'b0;
         read_q       <= '0;
         data_out_q   <= '0;
         data_oe_q    <= 1'b0;
         pix_data_q   <= '0;
         pix_idx_q    <= '0;
         pix_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef FRAME_CNT_EN
         frame_cnt_q  <= '0;
         overrun_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         erase_q      <= erase_d;
         expose_q     <= expose_d;
         convert_q    <= convert_d;
         read_q       <= read_d;
         data_out_q   <= data_out_d;
         data_oe_q    <= data_oe_d;
         pix_data_q   <= pix_data_d;
         pix_idx_q    <= pix_idx_d;
         pix_valid_q  <= pix_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
`ifdef FRAME_CNT_EN
         frame_cnt_q  <= frame_cnt_d;
         overrun_q    <= overrun_d;
`endif
      end
   end

   assign ERASE      = erase_q;
   assign EXPOSE     = expose_q;
   assign CONVERT    = convert_q;
   assign READ1      = read_q[0];
   assign READ2      = read_q[1];
   assign READ3      = read_q[2];
   assign READ4      = read_q[3];
   assign DATA_OUT   = data_out_q;
   assign DATA_OE    = data_oe_q;
   assign pix_data   = pix_data_q;
   assign pix_idx    = pix_idx_q;
   assign pix_valid  = pix_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
`ifdef FRAME_CNT_EN
   assign frame_cnt  = frame_cnt_q;
   assign overrun    = overrun_q;
`endif

endmodule

// File: tb/tb_pixel_array_readout.sv
// Directed bench for pixel_array_readout: cycle-exact phase checks plus a sample scoreboard.
// Build with FRAME_CNT_EN defined to also cover frame_cnt and overrun.
module tb_pixel_array_readout;

   localparam int DATA_W     = 8;
   localparam int ERASE_CYC  = 5;
   localparam int EXPOSE_CYC = 255;
   localparam int READ_CYC   = 2;
   localparam int CONV_CYC   = 256;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic              ERASE, EXPOSE, CONVERT, READ1, READ2, READ3, READ4;
   logic [DATA_W-1:0] DATA_OUT;
   logic              DATA_OE;
   logic [DATA_W-1:0] DATA_IN;
   logic [DATA_W-1:0] pix_data;
   logic [1:0]        pix_idx;
   logic              pix_valid;
   logic              pix_ready;
   logic              busy;
   logic              frame_done;
`ifdef FRAME_CNT_EN
   logic [15:0]       frame_cnt;
   logic              overrun;
   int                exp_frames = 0;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]        idx;
      logic [DATA_W-1:0] data;
   } exp_t;
   exp_t sb[$];

   logic [DATA_W-1:0] pix_val [4];
   logic [DATA_W-1:0] pix_xor;
   logic [3:0]        rd;

   pixel_array_readout #(
      .DATA_W    (DATA_W),
      .ERASE_CYC (ERASE_CYC),
      .EXPOSE_CYC(EXPOSE_CYC),
      .READ_CYC  (READ_CYC)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .ERASE     (ERASE),
      .EXPOSE    (EXPOSE),
      .CONVERT   (CONVERT),
      .READ1     (READ1),
      .READ2     (READ2),
      .READ3     (READ3),
      .READ4     (READ4),
      .DATA_OUT  (DATA_OUT),
      .DATA_OE   (DATA_OE),
      .DATA_IN   (DATA_IN),
      .pix_data  (pix_data),
      .pix_idx   (pix_idx),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .busy      (busy),
      .frame_done(frame_done)
`ifdef FRAME_CNT_EN
      ,
      .frame_cnt (frame_cnt),
      .overrun   (overrun)
`endif
   );

   always #5 clk = ~clk;

   assign rd = {READ4, READ3, READ2, READ1};

   // Pixel model: the selected pixel drives the bus, otherwise a marker value floats on it.
   always_comb begin
      DATA_IN = 8'hA5;
      case (rd)
         4'b0001: DATA_IN = pix_val[0] ^ pix_xor;
         4'b0010: DATA_IN = pix_val[1] ^ pix_xor;
         4'b0100: DATA_IN = pix_val[2] ^ pix_xor;
         4'b1000: DATA_IN = pix_val[3] ^ pix_xor;
         default: DATA_IN = 8'hA5;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         checks++;
         assert ($countones(rd) <= 1) else begin
            errors++;
            $error("FAIL inv_read_onehot observed %b expected at most one bit", rd);
         end
         checks++;
         assert (!(DATA_OE && (rd != 4'b0000))) else begin
            errors++;
            $error("FAIL inv_oe_vs_read observed oe=%b read=%b expected no overlap", DATA_OE, rd);
         end
         checks++;
         assert ($countones({ERASE, EXPOSE, CONVERT}) <= 1) else begin
            errors++;
            $error("FAIL inv_phase_excl observed %b expected at most one bit", {ERASE, EXPOSE, CONVERT});
         end
      end
   end

   task automatic read_pixel(input int idx, input int stall);
      exp_t e;
      if (stall > 0) pix_ready = 1'b0;
      for (int c = 0; c < READ_CYC; c++) begin
         @(negedge clk);
         chk("read_sel", rd, 32'(4'b0001 << idx));
         chk("read_oe", DATA_OE, 0);
         chk("read_valid", pix_valid, 0);
      end
      e = sb[0];
      for (int h = 0; h <= stall; h++) begin
         @(negedge clk);
         chk("hold_valid", pix_valid, 1);
         chk("hold_read", rd, 0);
         chk("hold_data", pix_data, e.data);
         chk("hold_idx", pix_idx, e.idx);
         chk("hold_busy", busy, 1);
         if (h == stall) pix_ready = 1'b1;
      end
      void'(sb.pop_front());
      @(negedge clk);
      chk("post_valid", pix_valid, 0);
      chk("post_read", rd, 0);
      if (idx < 3) begin
         chk("gap_done", frame_done, 0);
         chk("gap_busy", busy, 1);
      end else begin
         chk("done_pulse", frame_done, 1);
         chk("done_busy", busy, 0);
`ifdef FRAME_CNT_EN
         exp_frames++;
         chk("frame_cnt", frame_cnt, 32'(exp_frames));
`endif
      end
   endtask

   task automatic run_frame(input int stall_idx, input int stall_len, input bit hammer);
      logic prev_start;
      for (int p = 0; p < 4; p++) begin
         exp_t e;
         e.idx  = 2'(p);
         e.data = pix_val[p] ^ pix_xor;
         sb.push_back(e);
      end
      start = 1'b1;
      for (int i = 0; i < ERASE_CYC; i++) begin
         @(negedge clk);
         start = 1'b0;
         chk("erase_hi", ERASE, 1);
         chk("erase_expose", EXPOSE, 0);
         chk("erase_busy", busy, 1);
      end
      prev_start = 1'b0;
      for (int i = 0; i < EXPOSE_CYC; i++) begin
         @(negedge clk);
         chk("expose_hi", EXPOSE, 1);
         chk("expose_erase", ERASE, 0);
         chk("expose_conv", CONVERT, 0);
`ifdef FRAME_CNT_EN
         chk("overrun", overrun, 32'(prev_start));
`endif
         start = hammer && (i % 2 == 0) && (i < EXPOSE_CYC - 2);
         prev_start = start;
      end
      for (int i = 0; i < CONV_CYC; i++) begin
         @(negedge clk);
         start = 1'b0;
         chk("conv_hi", CONVERT, 1);
         chk("conv_oe", DATA_OE, 1);
         chk("conv_count", DATA_OUT, 32'(i));
         chk("conv_expose", EXPOSE, 0);
`ifdef FRAME_CNT_EN
         if (i == 0) chk("overrun_last", overrun, 32'(prev_start));
`endif
      end
      @(negedge clk);
      chk("turn_conv", CONVERT, 0);
      chk("turn_oe", DATA_OE, 0);
      chk("turn_data", DATA_OUT, 0);
      chk("turn_read", rd, 0);
      chk("turn_busy", busy, 1);
      for (int p = 0; p < 4; p++) read_pixel(p, (p == stall_idx) ? stall_len : 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_busy", busy, 0);
         chk("idle_erase", ERASE, 0);
         chk("idle_done", frame_done, 0);
      end
      chk("sb_empty", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      pix_val[0] = 8'h12;
      pix_val[1] = 8'h34;
      pix_val[2] = 8'h56;
      pix_val[3] = 8'h78;
      pix_xor    = 8'h00;
      reset_n    = 1'b0;
      start      = 1'b0;
      pix_ready  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {ERASE, EXPOSE, CONVERT, rd, DATA_OE, pix_valid, busy, frame_done}, 0);
      chk("rst_data", {DATA_OUT, pix_data, pix_idx}, 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_after_rst", busy, 0);

      run_frame(-1, 0, 1'b0);
      run_frame(1, 10, 1'b0);

      // Abort a frame mid-conversion.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (CONVERT && DATA_OUT == 8'h80) begin
            found = 1'b1;
            break;
         end
      end
      chk("reach_conv80", found, 1);
      reset_n = 1'b0;
      #1;
      chk("abort_outputs", {ERASE, EXPOSE, CONVERT, rd, DATA_OE, pix_valid, busy, frame_done}, 0);
      chk("abort_data", {DATA_OUT, pix_data, pix_idx}, 0);
`ifdef FRAME_CNT_EN
      chk("abort_frame_cnt", frame_cnt, 0);
      exp_frames = 0;
`endif
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_after_abort", busy, 0);

      pix_xor = 8'hC3;
      run_frame(-1, 0, 1'b1);
`ifdef FRAME_CNT_EN
      chk("frame_cnt_final", frame_cnt, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_array_readout.md
Name: pixel_array_readout

Overview:
Digital sequencer and readout controller on the host side of the 2x2 pixel array's shared 8-bit DATA bus.
- Runs one frame per start request: ERASE, EXPOSE, CONVERT and per-pixel READ1..READ4.
- During CONVERT it drives the conversion count onto DATA.
- During readout it samples the pixel-driven bus and delivers samples on a valid/ready stream.

Parameters:
DATA_W, 8, width of DATA bus and conversion counter
ERASE_CYC, 5, cycles ERASE held high (>=1)
EXPOSE_CYC, 255, cycles EXPOSE held high (>=1)
READ_CYC, 2, cycles each READn held before sampling (>=2)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  frame request; sampled in IDLE only
ERASE  output  1  pixel erase, to all pixels
EXPOSE  output  1  pixel expose, to all pixels
CONVERT  output  1  high while ramp/count conversion runs
READ1..READ4  output  1 each  per-pixel bus-drive select, one-hot or zero
DATA_OUT  output  DATA_W  conversion count driven onto DATA
DATA_OE  output  1  tristate enable for DATA_OUT
DATA_IN  input  DATA_W  DATA bus as seen by the controller
pix_data  output  DATA_W  captured pixel value
pix_idx  output  2  pixel index 0..3 (READ1=0)
pix_valid  output  1  pix_data/pix_idx valid
pix_ready  input  1  downstream accept
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; counters 0. Takes effect mid-frame immediately; no partial sample delivered.
- FSM states: IDLE, ERASE, EXPOSE, CONVERT, TURN, READ, HOLD, GAP.
- IDLE: start=1 -> ERASE next cycle. start while busy is ignored, not queued.
- ERASE: ERASE=1 for exactly ERASE_CYC cycles -> EXPOSE.
- EXPOSE: EXPOSE=1 for exactly EXPOSE_CYC cycles -> CONVERT.
- CONVERT:
  - CONVERT=1, DATA_OE=1 for 2^DATA_W cycles.
  - DATA_OUT=0 on first cycle, +1 per cycle, 2^DATA_W-1 on last. No wrap.
  - -> TURN.
- TURN: one cycle, all bus and control outputs 0 (bus turnaround) -> READ with idx=0.
- READ:
  - READ(idx+1)=1 for READ_CYC cycles.
  - On the last cycle, DATA_IN is registered into pix_data and idx into pix_idx.
  - Next cycle: pix_valid=1, READ deasserted -> HOLD.
- HOLD:
  - pix_valid=1; pix_data/pix_idx stable until pix_valid&pix_ready.
  - On accept: pix_valid=0 next cycle.
  - idx<3 -> GAP; idx==3 -> frame_done=1 for one cycle, then IDLE.
- GAP: one cycle, no READn high -> READ with idx+1.
- Invariants:
  - At most one READn high at any time.
  - DATA_OE never high in the same cycle as any READn.
  - ERASE/EXPOSE/CONVERT mutually exclusive.
- Counters are sized by $clog2 of the largest phase length. The phase counter clears on every state entry.

Optional Feature:
FRAME_CNT_EN
- Defined:
  - Adds output frame_cnt (16 bits), reset 0.
  - Increments in the cycle frame_done pulses; wraps 0xFFFF->0.
  - Adds output overrun: 1-cycle pulse when start=1 arrives while busy.
- Not defined: neither port exists; no extra logic.

Test Plan:
- Reset then start pulse with defaults -> ERASE high 5 cycles, EXPOSE high 255, CONVERT high 256 with DATA_OUT 0..255 and DATA_OE=1, then 1 idle TURN cycle.
- Pixel model drives 0x12,0x34,0x56,0x78 when READ1..4 high, pix_ready tied 1 -> four samples idx 0..3 with those values, frame_done pulses once, busy falls the same cycle as IDLE entry.
- pix_ready held 0 for 10 cycles on idx 1 -> pix_valid stays 1, pix_data=0x34 stable, READ3 not asserted until accept.
- reset_n pulled low during CONVERT count 0x80 -> all outputs 0 immediately; a fresh start yields a complete, correct frame.
- start asserted repeatedly during EXPOSE -> no restart; exactly one frame_done. With FRAME_CNT_EN: overrun pulses per such start, frame_cnt=1 afterwards.
- Assertion monitor over all tests -> never two READn high, never DATA_OE with any READn.
